// File: rtl/sprite_blitter_pkg.sv
// Shared constants and FSM state type for the sprite blitter.
// Screen/sprite geometry, transparent key colour and framebuffer address width.
package sprite_blitter_pkg;

    localparam int          SCR_W = 640;
    localparam int          SCR_H = 480;
    localparam int          SPR_W = 64;
    localparam int          SPR_H = 20;
    localparam logic [15:0] KEY   = 16'h0000;
    localparam int          FB_AW = 19;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/sprite_blitter_addr.sv
// fb_addr_calc: combinational framebuffer address y*SCR_W + x.
// The multiply by the constant screen width is unrolled into a sum of shifted copies of y.
module fb_addr_calc
    import sprite_blitter_pkg::FB_AW;
#(
    parameter int SCR_W = sprite_blitter_pkg::SCR_W
) (
    input  logic [10:0]      x,
    input  logic [10:0]      y,
    output logic [FB_AW-1:0] addr
);

    localparam logic [FB_AW-1:0] WIDTH = FB_AW'(SCR_W);

    logic [FB_AW-1:0] acc;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        acc = '0;
        for (int i = 0; i < FB_AW; i++) begin
            if (WIDTH[i]) begin
                acc = acc + (FB_AW'(y) << i);
            end
        end
        addr = acc + FB_AW'(x);
    end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: walks a SPR_W x SPR_H sprite ROM in row-major order and writes the
// non-transparent, on-screen pixels into the framebuffer at the latched position.
module sprite_blitter
    import sprite_blitter_pkg::state_t,
           sprite_blitter_pkg::IDLE,
           sprite_blitter_pkg::RUN,
           sprite_blitter_pkg::DRAIN,
           sprite_blitter_pkg::DONE,
           sprite_blitter_pkg::FB_AW;
#(
    parameter int          SPR_W = sprite_blitter_pkg::SPR_W,
    parameter int          SPR_H = sprite_blitter_pkg::SPR_H,
    parameter int          SCR_W = sprite_blitter_pkg::SCR_W,
    parameter int          SCR_H = sprite_blitter_pkg::SCR_H,
    parameter logic [15:0] KEY   = sprite_blitter_pkg::KEY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [9:0]       pos_x,
    input  logic [9:0]       pos_y,
    output logic             busy,
    output logic             done,
    output logic [5:0]       rom_x,
    output logic [5:0]       rom_y,
    input  logic [15:0]      rom_rgb,
    output logic             fb_we,
    output logic [FB_AW-1:0] fb_addr,
    output logic [15:0]      fb_data
);

    localparam logic [5:0] X_LAST = 6'(SPR_W - 1);
    localparam logic [5:0] Y_LAST = 6'(SPR_H - 1);

    state_t           state, state_nxt;
    logic [9:0]       pos_x_q, pos_y_q;
    logic             drain_cnt;
    logic             p1_valid;
    logic [5:0]       p1_x, p1_y;
    logic [10:0]      scr_x, scr_y;
    logic             in_bounds;
    logic             last_pix;
    logic [FB_AW-1:0] addr_calc;

    assign last_pix = (rom_x == X_LAST) && (rom_y == Y_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = RUN;
            RUN:     if (last_pix)  state_nxt = DRAIN;
            DRAIN:   if (drain_cnt) state_nxt = DONE;
            DONE:                   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);

    // Screen coordinates are 11 bits wide so an off-screen pixel never wraps back on screen.
    assign scr_x     = {1'b0, pos_x_q} + {5'b0, p1_x};
    assign scr_y     = {1'b0, pos_y_q} + {5'b0, p1_y};
    assign in_bounds = (scr_x < 11'(SCR_W)) && (scr_y < 11'(SCR_H));

    fb_addr_calc #(
        .SCR_W (SCR_W)
    ) u_addr (
        .x    (scr_x),
        .y    (scr_y),
        .addr (addr_calc)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            rom_x     <= '0;
            rom_y     <= '0;
            drain_cnt <= 1'b0;
            p1_valid  <= 1'b0;
            p1_x      <= '0;
            p1_y      <= '0;
            fb_we     <= 1'b0;
            fb_addr   <= '0;
            fb_data   <= '0;
        end else begin
            state <= state_nxt;

            if (state == IDLE && start) begin
                pos_x_q <= pos_x;
                pos_y_q <= pos_y;
                rom_x   <= '0;
                rom_y   <= '0;
            end else if (state == RUN && !last_pix) begin
                if (rom_x == X_LAST) begin
                    rom_x <= '0;
                    rom_y <= rom_y + 6'd1;
                end else begin
                    rom_x <= rom_x + 6'd1;
                end
            end

            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;

            // Coordinate pipeline runs freely; it lines up with the one-cycle ROM read.
            p1_valid <= (state == RUN);
            p1_x     <= rom_x;
            p1_y     <= rom_y;

            fb_we   <= p1_valid && (rom_rgb != KEY) && in_bounds;
            fb_addr <= addr_calc;
            fb_data <= rom_rgb;
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: ROM model with one-cycle latency, write monitor,
// hand-computed expectations for position, clipping, keying, start filtering and reset abort.
module tb_sprite_blitter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  pos_x = '0;
    logic [9:0]  pos_y = '0;
    logic        busy, done;
    logic [5:0]  rom_x, rom_y;
    logic [15:0] rom_rgb = '0;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [15:0] fb_data;

    sprite_blitter dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pos_x   (pos_x),
        .pos_y   (pos_y),
        .busy    (busy),
        .done    (done),
        .rom_x   (rom_x),
        .rom_y   (rom_y),
        .rom_rgb (rom_rgb),
        .fb_we   (fb_we),
        .fb_addr (fb_addr),
        .fb_data (fb_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM model: mode 0 solid red, mode 1 checkerboard with KEY on odd (x+y).
    int mode = 0;
    always @(posedge clk) begin
        if (mode == 1 && ((int'(rom_x) + int'(rom_y)) % 2) == 1)
            rom_rgb <= 16'h0000;
        else
            rom_rgb <= 16'hF800;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor statistics for the current blit run.
    int t0 = 0;
    int cur_px = 0, cur_py = 0, rst_at_g = -1;
    int n_writes, n_writes_a, n_writes_b, first_addr, last_addr;
    int bad_wr, oob, odd_par, n_done, done_rel, n_rises, rise_cyc;
    int busy_first_rel, busy_last_rel, rise2_rel, late;
    bit prev_busy = 1'b0;

    task automatic clear_stats();
        n_writes = 0; n_writes_a = 0; n_writes_b = 0;
        first_addr = -1; last_addr = -1;
        bad_wr = 0; oob = 0; odd_par = 0;
        n_done = 0; done_rel = -1; n_rises = 0; rise_cyc = 0;
        busy_first_rel = -1; busy_last_rel = -1; rise2_rel = -1; late = 0;
    endtask

    always @(negedge clk) begin
        int k, sx, sy, exp_addr, rel;
        rel = cyc - t0;
        if (busy && !prev_busy) begin
            n_rises++;
            rise_cyc = cyc;
            if (n_rises == 1) busy_first_rel = rel;
            if (n_rises == 2) rise2_rel = rel;
        end
        if (busy && n_rises == 1) busy_last_rel = rel;
        if (fb_we) begin
            k        = cyc - rise_cyc - 2;
            sx       = k % 64;
            sy       = k / 64;
            exp_addr = (cur_py + sy) * 640 + cur_px + sx;
            if (int'(fb_addr) != exp_addr || fb_data != 16'hF800) bad_wr++;
            if (int'(fb_addr) >= 307200) oob++;
            if (((int'(fb_addr) % 640) + (int'(fb_addr) / 640)) % 2 == 1) odd_par++;
            if (n_writes == 0) first_addr = int'(fb_addr);
            last_addr = int'(fb_addr);
            n_writes++;
            if (n_rises >= 2) n_writes_b++; else n_writes_a++;
        end
        if (done) begin
            if (n_done == 0) done_rel = rel;
            n_done++;
        end
        if (rst_at_g >= 0 && rel > rst_at_g && (busy || fb_we)) late++;
        prev_busy = busy;
    end

    // One run of n_cyc cycles from C0, with optional extra start pulses, a reset pulse
    // or start held high for back-to-back blits.
    task automatic blit(input int px, input int py, input int pulse_a, input int pulse_b,
                        input int rst_at, input bit hold, input int n_cyc);
        clear_stats();
        cur_px   = px;
        cur_py   = py;
        rst_at_g = rst_at;
        @(negedge clk);
        pos_x = 10'(px);
        pos_y = 10'(py);
        t0    = cyc;
        for (int rel = 0; rel < n_cyc; rel++) begin
            if (rel > 0) @(negedge clk);
            start = (rel == 0) || (rel == pulse_a) || (rel == pulse_b) || (hold && rel < 2568);
            rst   = (rel == rst_at);
        end
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        clear_stats();
        repeat (2) @(negedge clk);
        check("reset busy",    int'(busy),    0);
        check("reset done",    int'(done),    0);
        check("reset fb_we",   int'(fb_we),   0);
        check("reset fb_addr", int'(fb_addr), 0);
        check("reset fb_data", int'(fb_data), 0);
        check("reset rom_x",   int'(rom_x),   0);
        check("reset rom_y",   int'(rom_y),   0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Solid sprite fully on screen.
        mode = 0;
        blit(100, 50, -1, -1, -1, 1'b0, 1290);
        check("solid writes",     n_writes,       1280);
        check("solid first addr", first_addr,     32100);
        check("solid last addr",  last_addr,      44323);
        check("solid addr/data",  bad_wr,         0);
        check("solid done cycle", done_rel,       1283);
        check("solid done count", n_done,         1);
        check("solid busy rise",  busy_first_rel, 1);
        check("solid busy fall",  busy_last_rel,  1282);

        // Sprite clipped at the bottom-right corner.
        blit(600, 470, -1, -1, -1, 1'b0, 1290);
        check("clip writes",     n_writes,  400);
        check("clip out of fb",  oob,       0);
        check("clip last addr",  last_addr, 307199);
        check("clip addr/data",  bad_wr,    0);
        check("clip done cycle", done_rel,  1283);

        // Checkerboard with transparent key.
        mode = 1;
        blit(0, 0, -1, -1, -1, 1'b0, 1290);
        check("checker writes",   n_writes, 640);
        check("checker odd sx+sy", odd_par, 0);
        check("checker addr/data", bad_wr,  0);
        mode = 0;

        // Start pulses during RUN and during DONE are ignored.
        blit(100, 50, 10, 1283, -1, 1'b0, 1290);
        check("restart done count", n_done,   1);
        check("restart busy rises", n_rises,  1);
        check("restart done cycle", done_rel, 1283);
        check("restart writes",     n_writes, 1280);
        check("restart addr/data",  bad_wr,   0);

        // Reset mid-blit aborts it.
        blit(100, 50, -1, -1, 500, 1'b0, 1290);
        check("abort activity", late,   0);
        check("abort done",     n_done, 0);
        blit(0, 0, -1, -1, -1, 1'b0, 1290);
        check("after abort first addr", first_addr, 0);
        check("after abort writes",     n_writes,   1280);
        check("after abort addr/data",  bad_wr,     0);

        // Start held high: two back-to-back blits.
        blit(600, 470, -1, -1, -1, 1'b1, 2575);
        check("b2b second busy rise", rise2_rel,  1285);
        check("b2b first writes",     n_writes_a, 400);
        check("b2b second writes",    n_writes_b, 400);
        check("b2b done count",       n_done,     2);
        check("b2b addr/data",        bad_wr,     0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
